// File: rtl/arb_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, owner ids and counter widths.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  // Wide enough for STARVE_MAX up to 15 and MEM_LAT up to 7.
  localparam int unsigned STARVE_W = 4;
  localparam int unsigned LAT_W    = 3;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of debug grants made while the CPU was left waiting.
module arb_starve_ctr
  import arb_pkg::*;
#(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [STARVE_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != STARVE_W'(MAX))) begin
      count <= count + STARVE_W'(1);
    end
  end

  assign at_max = (count == STARVE_W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU and the debug loader; one access in flight,
// fixed read latency, one-cycle ack with registered read data per requester.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned AW         = 10,
  parameter int unsigned DW         = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner,
  output logic          busy
);

  arb_state_t       state;
  logic [LAT_W-1:0] latCnt;
  logic             accWe;
  logic             cpuWins;
  logic             starveAtMax;
  logic             starveInc;
  logic             starveClr;

  // Debug has priority unless the CPU has been passed over STARVE_MAX times in a row.
  assign cpuWins   = cpu_req & (~dbg_req | starveAtMax);
  assign starveInc = (state == IDLE) & dbg_req & cpu_req & ~starveAtMax;
  assign starveClr = (state == IDLE) & (~cpu_req | cpuWins);

  arb_starve_ctr #(
    .MAX(STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (starveInc),
    .clr   (starveClr),
    .at_max(starveAtMax)
  );

  assign cpu_stall = cpu_req & ~cpu_ack;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      latCnt    <= '0;
      accWe     <= 1'b0;
      owner     <= OWN_CPU;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_ack   <= 1'b0;
      dbg_ack   <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      case (state)
        IDLE: begin
          // Request fields are latched here; later changes by the requester are ignored.
          if (cpu_req | dbg_req) begin
            owner     <= cpuWins ? OWN_CPU : OWN_DBG;
            accWe     <= cpuWins ? cpu_we : dbg_we;
            mem_we    <= cpuWins ? cpu_we : dbg_we;
            mem_addr  <= cpuWins ? cpu_addr : dbg_addr;
            mem_wdata <= cpuWins ? cpu_wdata : dbg_wdata;
            mem_en    <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          latCnt <= LAT_W'(MEM_LAT);
          state  <= WAIT;
        end
        WAIT: begin
          latCnt <= latCnt - LAT_W'(1);
          if (latCnt == LAT_W'(1)) begin
            if (!accWe) begin
              if (owner == OWN_CPU) cpu_rdata <= mem_rdata;
              else                  dbg_rdata <= mem_rdata;
            end
            if (owner == OWN_CPU) cpu_ack <= 1'b1;
            else                  dbg_ack <= 1'b1;
            state <= ACK;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: a transaction-level arbiter model queues expected issues and acks,
// a separate monitor pops and compares whenever the DUT strobes mem_en or an ack.
module tb_mem_port_arbiter;

  localparam int unsigned AW     = 10;
  localparam int unsigned DW     = 32;
  localparam int unsigned LAT    = 1;
  localparam int unsigned STARVE = 4;
  localparam int unsigned DEPTH  = 1 << AW;

  logic          clk;
  logic          reset;
  logic          cpu_req, cpu_we, dbg_req, dbg_we;
  logic [AW-1:0] cpu_addr, dbg_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic          cpu_ack, cpu_stall, dbg_ack, mem_en, mem_we, owner, busy;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_MAX(STARVE)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory device: data valid exactly LAT edges after mem_en, garbage otherwise.
  logic [DW-1:0] memArr [DEPTH];
  logic [DW-1:0] pipe [LAT];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= mem_en ? memArr[mem_addr] : DW'($urandom);
    if (mem_en && mem_we) memArr[mem_addr] = mem_wdata;
  end
  assign mem_rdata = pipe[LAT-1];

  typedef struct {
    int            cyc;
    bit            owner;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
  } txn_t;

  txn_t          issueQ[$];
  txn_t          ackQ[$];
  logic [DW-1:0] memModel [DEPTH];
  logic [DW-1:0] expCpuRd, expDbgRd;
  int            nextFree, starve;
  int            nCmp = 0;
  int            nErr = 0;
  bit            checkOn = 0;

  // Requester state, index 0 = CPU, 1 = debug.
  logic          rq [2];
  logic          rwe [2];
  logic [AW-1:0] raddr [2];
  logic [DW-1:0] rwd [2];
  bit            granted [2];
  int            grantAt [2];
  int            ackAt [2];
  int            pNew [2];
  int            pViol;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic applyPins();
    cpu_req = rq[0]; cpu_we = rwe[0]; cpu_addr = raddr[0]; cpu_wdata = rwd[0];
    dbg_req = rq[1]; dbg_we = rwe[1]; dbg_addr = raddr[1]; dbg_wdata = rwd[1];
  endtask

  task automatic newFields(input int r);
    rwe[r]   = ($urandom_range(0, 1) == 1);
    raddr[r] = AW'($urandom_range(0, 15));
    rwd[r]   = DW'($urandom);
  endtask

  task automatic setReq(input int r, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rq[r] = 1'b1; rwe[r] = we; raddr[r] = a; rwd[r] = d;
  endtask

  // Reference arbiter: one access per 3+LAT cycles, debug first unless the CPU is starved.
  task automatic arbitrate();
    txn_t t;
    int   w;
    if (cyc < nextFree) return;
    if (!rq[0]) starve = 0;
    if (!(rq[0] || rq[1])) return;
    w = (rq[0] && (!rq[1] || starve == STARVE)) ? 0 : 1;
    if (w == 0) starve = 0;
    else if (rq[0] && starve < STARVE) starve++;
    t.owner = (w == 1);
    t.we    = rwe[w];
    t.addr  = raddr[w];
    t.wd    = rwd[w];
    t.rd    = memModel[raddr[w]];
    if (t.we) memModel[t.addr] = t.wd;
    t.cyc = cyc + 1;
    issueQ.push_back(t);
    t.cyc = cyc + 2 + LAT;
    ackQ.push_back(t);
    granted[w] = 1;
    grantAt[w] = cyc;
    ackAt[w]   = t.cyc;
    nextFree   = cyc + 3 + LAT;
  endtask

  task automatic tick();
    for (int r = 0; r < 2; r++) begin
      if (granted[r] && cyc == ackAt[r]) begin
        granted[r] = 0;
        if ($urandom_range(0, 99) < pNew[r]) begin rq[r] = 1'b1; newFields(r); end
        else rq[r] = 1'b0;
      end else if (granted[r] && cyc == grantAt[r] + 1 && $urandom_range(0, 99) < pViol) begin
        rq[r] = 1'b0;
        newFields(r);
      end else if (!granted[r] && !rq[r] && $urandom_range(0, 99) < pNew[r]) begin
        rq[r] = 1'b1;
        newFields(r);
      end
    end
    arbitrate();
    applyPins();
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      tick();
    end
  endtask

  task automatic monitorCycle();
    txn_t t;
    bit   expBusy, expCpuAck;
    expBusy   = (ackQ.size() > 0) && (cyc >= ackQ[0].cyc - int'(1 + LAT));
    expCpuAck = (ackQ.size() > 0) && (ackQ[0].cyc == cyc) && !ackQ[0].owner;
    chk("busy", 64'(busy), 64'(expBusy));
    chk("cpu_stall", 64'(cpu_stall), 64'(rq[0] && !expCpuAck));
    chk("mem_we_qualified", 64'(mem_we && !mem_en), 64'(0));
    if (mem_en) begin
      if (issueQ.size() == 0) chk("mem_en_unexpected", 64'(mem_en), 64'(0));
      else begin
        t = issueQ.pop_front();
        chk("issue_cycle", 64'(cyc), 64'(t.cyc));
        chk("mem_addr", 64'(mem_addr), 64'(t.addr));
        chk("mem_we", 64'(mem_we), 64'(t.we));
        if (t.we) chk("mem_wdata", 64'(mem_wdata), 64'(t.wd));
        chk("owner_issue", 64'(owner), 64'(t.owner));
      end
    end else if (issueQ.size() > 0 && issueQ[0].cyc <= cyc) begin
      chk("mem_en_missing", 64'(mem_en), 64'(1));
      void'(issueQ.pop_front());
    end
    if (cpu_ack || dbg_ack) begin
      if (ackQ.size() == 0) chk("ack_unexpected", 64'({cpu_ack, dbg_ack}), 64'(0));
      else begin
        t = ackQ.pop_front();
        chk("ack_cycle", 64'(cyc), 64'(t.cyc));
        chk("ack_who", 64'({cpu_ack, dbg_ack}), t.owner ? 64'(1) : 64'(2));
        chk("owner_ack", 64'(owner), 64'(t.owner));
        if (!t.we) begin
          if (t.owner) expDbgRd = t.rd;
          else         expCpuRd = t.rd;
        end
      end
    end else if (ackQ.size() > 0 && ackQ[0].cyc <= cyc) begin
      chk("ack_missing", 64'(cpu_ack | dbg_ack), 64'(1));
      void'(ackQ.pop_front());
    end
    chk("cpu_rdata", 64'(cpu_rdata), 64'(expCpuRd));
    chk("dbg_rdata", 64'(dbg_rdata), 64'(expDbgRd));
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (checkOn && !reset) monitorCycle();
  end

  task automatic flushModel();
    issueQ.delete();
    ackQ.delete();
    granted[0] = 0; granted[1] = 0;
    starve = 0;
    expCpuRd = '0;
    expDbgRd = '0;
  endtask

  initial begin
    logic [DW-1:0] v;
    for (int i = 0; i < int'(DEPTH); i++) begin
      v = DW'($urandom);
      memArr[i] = v;
      memModel[i] = v;
    end
    memArr[10'h010] = 32'hDEADBEEF;
    memModel[10'h010] = 32'hDEADBEEF;
    for (int r = 0; r < 2; r++) begin
      rq[r] = 1'b0; rwe[r] = 1'b0; raddr[r] = '0; rwd[r] = '0;
      granted[r] = 0; grantAt[r] = 0; ackAt[r] = 0; pNew[r] = 0;
    end
    pViol = 0;
    flushModel();
    nextFree = 0;
    applyPins();
    reset = 1'b1;

    // Reset values, with cpu_stall following cpu_req.
    repeat (3) @(negedge clk);
    chk("rst_cpu_ack", 64'(cpu_ack), 64'(0));
    chk("rst_dbg_ack", 64'(dbg_ack), 64'(0));
    chk("rst_cpu_rdata", 64'(cpu_rdata), 64'(0));
    chk("rst_dbg_rdata", 64'(dbg_rdata), 64'(0));
    chk("rst_mem_en", 64'(mem_en), 64'(0));
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_owner", 64'(owner), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_stall_low", 64'(cpu_stall), 64'(0));
    rq[0] = 1'b1; applyPins(); #1;
    chk("rst_stall_high", 64'(cpu_stall), 64'(1));
    rq[0] = 1'b0; applyPins();

    @(negedge clk);
    reset = 1'b0; nextFree = cyc; checkOn = 1;
    tick();

    // Single CPU read of a known word.
    @(negedge clk); setReq(0, 1'b0, 10'h010, '0); tick();
    runCycles(6);
    // Debug write, then CPU read of the same address.
    @(negedge clk); setReq(1, 1'b1, 10'h020, 32'h12345678); tick();
    runCycles(6);
    @(negedge clk); setReq(0, 1'b0, 10'h020, '0); tick();
    runCycles(6);
    // CPU drops its request right after the grant.
    pViol = 100;
    @(negedge clk); setReq(0, 1'b0, 10'h021, '0); tick();
    runCycles(6);
    pViol = 0;

    // Both requesters continuously busy: starvation limit shapes the grant order.
    pNew[0] = 100; pNew[1] = 100;
    runCycles(64);
    pNew[0] = 0; pNew[1] = 0;
    runCycles(20);

    // Random traffic with occasional protocol violations.
    pNew[0] = 30; pNew[1] = 30; pViol = 15;
    runCycles(800);
    pNew[0] = 0; pNew[1] = 0; pViol = 0;
    runCycles(20);

    // Reset during WAIT of a CPU read; the held request is reissued after release.
    @(negedge clk); setReq(0, 1'b0, 10'h010, '0); tick();
    @(negedge clk); tick();
    @(negedge clk);
    checkOn = 0;
    reset = 1'b1;
    #1;
    chk("midrst_mem_en", 64'(mem_en), 64'(0));
    chk("midrst_mem_we", 64'(mem_we), 64'(0));
    chk("midrst_cpu_ack", 64'(cpu_ack), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_stall", 64'(cpu_stall), 64'(1));
    flushModel();
    repeat (2) begin
      @(negedge clk);
      chk("midrst_no_ack", 64'(cpu_ack | dbg_ack), 64'(0));
    end
    @(negedge clk);
    reset = 1'b0; nextFree = cyc; checkOn = 1;
    tick();
    runCycles(10);

    chk("issueQ_drained", 64'(issueQ.size()), 64'(0));
    chk("ackQ_drained", 64'(ackQ.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port between two requesters: the multicycle CPU (fetch, LW, SW accesses issued by the controller FSM) and the debug/program loader.
- Serialises requests, sequences each access through a fixed memory read latency, and returns a one-cycle ack with registered read data.
- Drives cpu_stall so the CPU controller holds its current state until its memory access completes.

Parameters:
- AW, 10: memory word-address width.
- DW, 32: data width.
- MEM_LAT, 1: clock edges from mem_en sampled high to mem_rdata valid (1..7).
- STARVE_MAX, 4: consecutive debug grants allowed while cpu_req is pending before the CPU is forced a grant (1..15).

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- cpu_req  input  1  CPU access request; held with we/addr/wdata stable until cpu_ack
- cpu_we  input  1  1 = write, 0 = read
- cpu_addr  input  AW  word address
- cpu_wdata  input  DW  write data
- cpu_ack  output  1  one-cycle completion pulse
- cpu_rdata  output  DW  registered read data; valid in the ack cycle, held until the next CPU read ack
- cpu_stall  output  1  cpu_req & ~cpu_ack (combinational)
- dbg_req, dbg_we, dbg_addr, dbg_wdata  input  1/1/AW/DW  debug requester; same rules as the CPU signals
- dbg_ack  output  1  one-cycle completion pulse
- dbg_rdata  output  DW  as cpu_rdata
- mem_en  output  1  memory access strobe, registered
- mem_we  output  1  memory write enable, registered, qualified by mem_en
- mem_addr  output  AW  registered address
- mem_wdata  output  DW  registered write data
- mem_rdata  input  DW  memory read data
- owner  output  1  0 = CPU, 1 = debug; holder of the current or last grant
- busy  output  1  state != IDLE

Behaviour:
- Reset values: all outputs 0 except cpu_stall, which follows cpu_req. state = IDLE; starvation counter = 0; latency counter = 0.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If any request is present, pick a winner.
  - Latch the winner's we/addr/wdata into the mem_* registers, set owner, go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE: mem_en = 1 for exactly this cycle. Load the latency counter with MEM_LAT. Go to WAIT.
- WAIT: decrement the counter each cycle. When the counter reaches 1, capture mem_rdata into the owner's rdata register on that edge (reads only). Go to ACK.
- ACK: assert the owner's ack for one cycle. Go to IDLE.
- Latency: req sampled in IDLE at cycle T0 -> mem_en at T1 -> ack at T(2+MEM_LAT). Writes use identical timing. Only one access is ever outstanding.
- Arbitration in IDLE:
  - Only one requester: that requester wins.
  - Both requesting: debug wins unless the starvation counter == STARVE_MAX, in which case the CPU wins.
- Starvation counter:
  - Increments on each debug grant made while cpu_req = 1.
  - Clears on any CPU grant, and in IDLE whenever cpu_req = 0.
  - Saturates at STARVE_MAX.
- Back-to-back requests: a req still high in the cycle after its ack is treated as a new request. Minimum spacing between accesses is 3+MEM_LAT cycles.
- Requester protocol violations:
  - A req dropped before its ack does not abort the access; the ack still pulses.
  - Changes to addr/wdata/we after the grant are ignored, because they were latched in IDLE.
- rdata registers: the non-owner's rdata is never modified. A write ack leaves the owner's rdata unchanged.
- Reset mid-operation: the in-flight access is abandoned. No ack is issued; mem_en and mem_we go to 0 immediately (asynchronous).

Decomposition:
- Shared package arb_pkg holds:
  - the state encoding localparams (IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, ACK = 2'd3);
  - owner ids OWN_CPU = 1'b0 and OWN_DBG = 1'b1.
- One natural sub-module, arb_starve_ctr: the saturating starvation counter with inc/clr inputs and an at_max output.
- The latency counter stays inline.

Test Plan:
- Single CPU read, MEM_LAT = 1: cpu_req = 1, addr = 0x010, memory holds 0xDEADBEEF -> mem_en at T1 with mem_addr = 0x010; cpu_ack at T3 with cpu_rdata = 0xDEADBEEF; cpu_stall high T0-T2, low at T3.
- Debug write then CPU read of the same address: dbg writes 0x12345678 to 0x020, then the CPU reads 0x020 -> mem_we = 1 only in the dbg ISSUE cycle; cpu_rdata = 0x12345678; dbg_rdata unchanged.
- Simultaneous requests with STARVE_MAX = 4 and dbg_req held high continuously -> grant order: dbg ×4, cpu, dbg ×4, cpu; owner toggles to match; the CPU ack arrives every 5th access.
- MEM_LAT = 3: a single debug read -> ack at T5. Change mem_rdata at T3 vs T4 and check that only the value present at the capture edge (end of T4) appears in dbg_rdata.
- Reset asserted during WAIT of a CPU read -> mem_en, mem_we, cpu_ack and busy = 0 at once; no ack ever follows; after release with cpu_req still high, the access is reissued, with mem_en in the second cycle after release.
- CPU drops req one cycle after the grant -> the access still completes, with cpu_ack pulsing at T3; state returns to IDLE with busy = 0 at T4.
